// File: rtl/div_duty_ctrl.sv
// div_duty_ctrl: run-time controller for a programmable clock divider.
// Produces clockout from clockin with divide ratio N (div_act) and high time H
// (high_act). New settings come in over a valid/ready handshake and are applied
// only at a period boundary, so clockout never produces a runt pulse.
// Optional feature macro: DIV_HALF_CYCLE_EN adds cfg_half and a negedge flop
// that stretches the high phase by half a clockin period.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | divider stopped, clockout low, configs load directly
// RUN   | divider counting with the active config
// PEND  | divider counting, validated config waiting in the shadow
module div_duty_ctrl #(
   parameter int CNT_W    = 8,
   parameter int DEF_DIV  = 4,
   parameter int DEF_HIGH = 2
) (
   input  logic             clockin,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic             cfg_valid,
`ifdef DIV_HALF_CYCLE_EN
   input  logic             cfg_half,
`endif
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clockout,
   output logic             period_tick,
   output logic             running
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_C      = CNT_W'(2);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] high_act_q, high_act_d;
   logic [CNT_W-1:0] shd_div_q, shd_div_d;
   logic [CNT_W-1:0] shd_high_q, shd_high_d;
   logic             clk_q, clk_d;
   logic             err_q, err_d;

   logic             accept;
   logic             cfg_ok;
   logic             boundary;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] new_high;

`ifdef DIV_HALF_CYCLE_EN
   logic             half_act_q, half_act_d;
   logic             shd_half_q, shd_half_d;
   logic             ext_q;
`endif

   // Handshake and period-boundary decode
   always_comb begin
      cfg_ready = (state_q != ST_PEND);
      accept    = cfg_valid & cfg_ready;
      // cfg_high < cfg_div is the same as cfg_high <= cfg_div-1 without underflow
      cfg_ok    = (cfg_div >= TWO_C) && (cfg_high != '0) && (cfg_high < cfg_div);
      boundary  = (state_q != ST_IDLE) && (cnt_q == (div_act_q - ONE_C));
      cnt_inc   = cnt_q + ONE_C;
   end

   // Next-state, counter, config and waveform logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      high_act_d = high_act_q;
      shd_div_d  = shd_div_q;
      shd_high_d = shd_high_q;
      clk_d      = clk_q;
      err_d      = accept & ~cfg_ok;
      new_high   = high_act_q;
`ifdef DIV_HALF_CYCLE_EN
      half_act_d = half_act_q;
      shd_half_d = shd_half_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (accept && cfg_ok) begin
               div_act_d  = cfg_div;
               high_act_d = cfg_high;
`ifdef DIV_HALF_CYCLE_EN
               half_act_d = cfg_half;
`endif
            end
            if (enable) begin
               state_d = ST_RUN;
               clk_d   = 1'b1;
            end
         end
         ST_RUN, ST_PEND: begin
            if (boundary) begin
               // Pick the values that govern the next period
               if (state_q == ST_PEND) begin
                  div_act_d  = shd_div_q;
                  high_act_d = shd_high_q;
                  new_high   = shd_high_q;
`ifdef DIV_HALF_CYCLE_EN
                  half_act_d = shd_half_q;
`endif
               end else if (accept && cfg_ok) begin
                  div_act_d  = cfg_div;
                  high_act_d = cfg_high;
                  new_high   = cfg_high;
`ifdef DIV_HALF_CYCLE_EN
                  half_act_d = cfg_half;
`endif
               end
               cnt_d = '0;
               if (enable) begin
                  state_d = ST_RUN;
                  clk_d   = (new_high != '0);
               end else begin
                  state_d = ST_IDLE;
                  clk_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_inc;
               clk_d = (cnt_inc < high_act_q);
               if ((state_q == ST_RUN) && accept && cfg_ok) begin
                  shd_div_d  = cfg_div;
                  shd_high_d = cfg_high;
`ifdef DIV_HALF_CYCLE_EN
                  shd_half_d = cfg_half;
`endif
                  state_d    = ST_PEND;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clockin or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_act_q  <= DEF_DIV_C;
         high_act_q <= DEF_HIGH_C;
         shd_div_q  <= '0;
         shd_high_q <= '0;
         clk_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         high_act_q <= high_act_d;
         shd_div_q  <= shd_div_d;
         shd_high_q <= shd_high_d;
         clk_q      <= clk_d;
         err_q      <= err_d;
      end
   end

`ifdef DIV_HALF_CYCLE_EN
   // Half-cycle configuration registers
   always_ff @(posedge clockin or negedge reset) begin
      if (!reset) begin
         half_act_q <= 1'b0;
         shd_half_q <= 1'b0;
      end else begin
         half_act_q <= half_act_d;
         shd_half_q <= shd_half_d;
      end
   end

   // Negedge copy of the high phase; keeps clockout high half a cycle past its fall
   always_ff @(negedge clockin or negedge reset) begin
      if (!reset) begin
         ext_q <= 1'b0;
      end else begin
         ext_q <= clk_q & half_act_q;
      end
   end

   // Output drive with half-cycle stretch
   always_comb begin
      clockout    = clk_q | ext_q;
      cfg_err     = err_q;
      period_tick = boundary;
      running     = (state_q != ST_IDLE);
   end
`else
   // Output drive
   always_comb begin
      clockout    = clk_q;
      cfg_err     = err_q;
      period_tick = boundary;
      running     = (state_q != ST_IDLE);
   end
`endif

endmodule

// File: tb/tb_div_duty_ctrl.sv
// Directed bench for div_duty_ctrl: defaults, mid-period reconfig, rejected
// configs, boundary-cycle config, stop/restart, reset with pending config and
// the maximum divide ratio.
module tb_div_duty_ctrl;

   logic       clockin = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] cfg_div;
   logic [7:0] cfg_high;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clockout;
   logic       period_tick;
   logic       running;
`ifdef DIV_HALF_CYCLE_EN
   logic       cfg_half = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clockin = ~clockin;

   div_duty_ctrl #(.CNT_W(8), .DEF_DIV(4), .DEF_HIGH(2)) dut (
      .clockin     (clockin),
      .reset       (reset),
      .enable      (enable),
      .cfg_div     (cfg_div),
      .cfg_high    (cfg_high),
      .cfg_valid   (cfg_valid),
`ifdef DIV_HALF_CYCLE_EN
      .cfg_half    (cfg_half),
`endif
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .clockout    (clockout),
      .period_tick (period_tick),
      .running     (running)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clockin);
      @(negedge clockin);
   endtask

   // One clockin cycle, then check the waveform outputs
   task automatic step(input string tag, input logic c, input logic t);
      tick();
      chk({tag, ".clk"}, 32'(clockout), 32'(c));
      chk({tag, ".tick"}, 32'(period_tick), 32'(t));
   endtask

   initial begin
      int highs;
      int tick_at;
      int ticks;

      reset     = 1'b0;
      enable    = 1'b0;
      cfg_div   = 8'd0;
      cfg_high  = 8'd0;
      cfg_valid = 1'b0;
      repeat (3) @(negedge clockin);

      // Reset values
      chk("rst.clk", 32'(clockout), 32'd0);
      chk("rst.tick", 32'(period_tick), 32'd0);
      chk("rst.err", 32'(cfg_err), 32'd0);
      chk("rst.run", 32'(running), 32'd0);
      chk("rst.ready", 32'(cfg_ready), 32'd1);

      // Test 1: defaults N=4 H=2, clockout 1,1,0,0
      reset  = 1'b1;
      enable = 1'b1;
      for (int p = 0; p < 3; p++) begin
         step("t1.c0", 1'b1, 1'b0);
         chk("t1.run", 32'(running), 32'd1);
         step("t1.c1", 1'b1, 1'b0);
         step("t1.c2", 1'b0, 1'b0);
         step("t1.c3", 1'b0, 1'b1);
      end

      // Test 2: offer N=5 H=1 at cnt=0, applied at next boundary
      step("t2.pre", 1'b1, 1'b0);
      chk("t2.ready0", 32'(cfg_ready), 32'd1);
      cfg_div   = 8'd5;
      cfg_high  = 8'd1;
      cfg_valid = 1'b1;
      step("t2.c1", 1'b1, 1'b0);
      cfg_valid = 1'b0;
      chk("t2.pend_ready", 32'(cfg_ready), 32'd0);
      step("t2.c2", 1'b0, 1'b0);
      chk("t2.pend_ready2", 32'(cfg_ready), 32'd0);
      step("t2.c3", 1'b0, 1'b1);
      step("t2.n0", 1'b1, 1'b0);
      chk("t2.ready_back", 32'(cfg_ready), 32'd1);
      step("t2.n1", 1'b0, 1'b0);
      step("t2.n2", 1'b0, 1'b0);
      step("t2.n3", 1'b0, 1'b0);
      step("t2.n4", 1'b0, 1'b1);
      step("t2.m0", 1'b1, 1'b0);

      // Test 3: N=1 H=1 then N=4 H=4 both rejected
      cfg_div   = 8'd1;
      cfg_high  = 8'd1;
      cfg_valid = 1'b1;
      step("t3.c1", 1'b0, 1'b0);
      chk("t3.err1", 32'(cfg_err), 32'd1);
      cfg_div  = 8'd4;
      cfg_high = 8'd4;
      step("t3.c2", 1'b0, 1'b0);
      chk("t3.err2", 32'(cfg_err), 32'd1);
      chk("t3.ready", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b0;
      step("t3.c3", 1'b0, 1'b0);
      chk("t3.err_clr", 32'(cfg_err), 32'd0);
      step("t3.c4", 1'b0, 1'b1);
      step("t3.m0", 1'b1, 1'b0);
      step("t3.m1", 1'b0, 1'b0);
      step("t3.m2", 1'b0, 1'b0);
      step("t3.m3", 1'b0, 1'b0);
      step("t3.m4", 1'b0, 1'b1);

      // Config N=6 H=3 offered on the boundary cycle: applies at once
      cfg_div   = 8'd6;
      cfg_high  = 8'd3;
      cfg_valid = 1'b1;
      step("bnd.c0", 1'b1, 1'b0);
      cfg_valid = 1'b0;
      chk("bnd.ready", 32'(cfg_ready), 32'd1);
      step("bnd.c1", 1'b1, 1'b0);

      // Test 4: enable=0 at cnt=1 of N=6 H=3
      enable = 1'b0;
      step("t4.c2", 1'b1, 1'b0);
      chk("t4.run_mid", 32'(running), 32'd1);
      step("t4.c3", 1'b0, 1'b0);
      step("t4.c4", 1'b0, 1'b0);
      step("t4.c5", 1'b0, 1'b1);
      step("t4.idle", 1'b0, 1'b0);
      chk("t4.run_off", 32'(running), 32'd0);
      step("t4.idle2", 1'b0, 1'b0);
      enable = 1'b1;
      step("t4.re0", 1'b1, 1'b0);
      chk("t4.run_on", 32'(running), 32'd1);

      // enable dropped and restored before the boundary: no gap
      enable = 1'b0;
      step("gap.c1", 1'b1, 1'b0);
      step("gap.c2", 1'b1, 1'b0);
      enable = 1'b1;
      step("gap.c3", 1'b0, 1'b0);
      step("gap.c4", 1'b0, 1'b0);
      step("gap.c5", 1'b0, 1'b1);
      step("gap.c0", 1'b1, 1'b0);
      chk("gap.run", 32'(running), 32'd1);

      // Test 5: reset during high phase with a pending config
      cfg_div   = 8'd8;
      cfg_high  = 8'd5;
      cfg_valid = 1'b1;
      step("t5.c1", 1'b1, 1'b0);
      cfg_valid = 1'b0;
      chk("t5.pend", 32'(cfg_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("t5.rst_clk", 32'(clockout), 32'd0);
      chk("t5.rst_run", 32'(running), 32'd0);
      chk("t5.rst_ready", 32'(cfg_ready), 32'd1);
      tick();
      reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
         step("t5.d0", 1'b1, 1'b0);
         step("t5.d1", 1'b1, 1'b0);
         step("t5.d2", 1'b0, 1'b0);
         step("t5.d3", 1'b0, 1'b1);
      end

      // Maximum ratio N=255 H=254, loaded while idle
      reset  = 1'b0;
      enable = 1'b0;
      tick();
      reset     = 1'b1;
      cfg_div   = 8'd255;
      cfg_high  = 8'd254;
      cfg_valid = 1'b1;
      step("max.idle", 1'b0, 1'b0);
      cfg_valid = 1'b0;
      chk("max.err", 32'(cfg_err), 32'd0);
      enable = 1'b1;
      step("max.c0", 1'b1, 1'b0);
      highs   = 1;
      tick_at = -1;
      ticks   = 0;
      for (int i = 1; i < 255; i++) begin
         tick();
         if (clockout === 1'b1) highs++;
         if (period_tick === 1'b1) begin
            ticks++;
            tick_at = i;
         end
      end
      chk("max.highs", 32'(highs), 32'd254);
      chk("max.tick_at", 32'(tick_at), 32'd254);
      chk("max.ticks", 32'(ticks), 32'd1);
      step("max.wrap", 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
